// File: rtl/program_counter.sv
// rtl/program_counter.sv - architectural PC register for the single-cycle RV32 core
//
// Holds the fetch address driven to instruction memory and loads the
// externally computed next PC on every enabled rising edge.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = asserted), released on the next edge
//   en         load enable: 1 = load nextPC, 0 = hold (stall)
//   nextPC     next fetch address computed by the core
//   currentPC  registered fetch address
//   pcPlus4    combinational currentPC + 4, wraps modulo 2^WIDTH
//   pcValid    registered; high once a non-reset address has been loaded
//   misaligned registered; raw nextPC[1:0] of the last accepted load was non-zero

module program_counter #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter bit               FORCE_ALIGN  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] nextPC,
  output logic [WIDTH-1:0] currentPC,
  output logic [WIDTH-1:0] pcPlus4,
  output logic             pcValid,
  output logic             misaligned
);

  logic [WIDTH-1:0] load_value;
  logic             load_misaligned;

  // The misaligned flag always reflects the raw target, even when the low
  // bits are stripped before the load, so the exception path can still see
  // that software asked for an unaligned address.
  assign load_misaligned = (nextPC[1:0] != 2'b00);

  generate
    if (FORCE_ALIGN) begin : g_align
      assign load_value = {nextPC[WIDTH-1:2], 2'b00};
    end else begin : g_raw
      assign load_value = nextPC;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      currentPC  <= RESET_VECTOR;
      pcValid    <= 1'b0;
      misaligned <= 1'b0;
    end else if (en) begin
      currentPC  <= load_value;
      pcValid    <= 1'b1;
      misaligned <= load_misaligned;
    end
  end

  // Natural truncation to WIDTH bits gives the modulo-2^WIDTH wrap.
  assign pcPlus4 = currentPC + WIDTH'(4);

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed self-checking bench for program_counter

module tb_program_counter;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] nextPC;

  logic [31:0] cur0, p40;
  logic        v0, m0;
  logic [31:0] cur1, p41;
  logic        v1, m1;
  logic [31:0] cur2, p42;
  logic        v2, m2;

  int checks;
  int errors;

  program_counter #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000), .FORCE_ALIGN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .en(en), .nextPC(nextPC),
    .currentPC(cur0), .pcPlus4(p40), .pcValid(v0), .misaligned(m0)
  );

  program_counter #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000), .FORCE_ALIGN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .en(en), .nextPC(nextPC),
    .currentPC(cur1), .pcPlus4(p41), .pcValid(v1), .misaligned(m1)
  );

  program_counter #(.WIDTH(32), .RESET_VECTOR(32'h0000_1000), .FORCE_ALIGN(1'b1)) dut2 (
    .clk(clk), .reset(reset), .en(en), .nextPC(nextPC),
    .currentPC(cur2), .pcPlus4(p42), .pcValid(v2), .misaligned(m2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    en     = 1'b1;
    nextPC = 32'h40;
    repeat (3) tick();
    checks++; if (cur0 !== 32'h0) begin errors++; $display("FAIL reset_cur actual=%h expected=%h", cur0, 32'h0); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b expected=0", v0); end
    checks++; if (m0 !== 1'b0) begin errors++; $display("FAIL reset_mis actual=%b expected=0", m0); end
    checks++; if (p40 !== 32'h4) begin errors++; $display("FAIL reset_plus4 actual=%h expected=%h", p40, 32'h4); end
    // release between edges, then load 0x100
    reset  = 1'b1;
    nextPC = 32'h100;
    tick();
    checks++; if (cur0 !== 32'h100) begin errors++; $display("FAIL load_100 actual=%h expected=%h", cur0, 32'h100); end
    // asynchronous assertion mid-cycle
    #2;
    reset = 1'b0;
    #1;
    checks++; if (cur0 !== 32'h0) begin errors++; $display("FAIL async_reset_cur actual=%h expected=%h", cur0, 32'h0); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL async_reset_valid actual=%b expected=0", v0); end
    // release and stall: pcValid must stay low with no load yet
    #1;
    reset  = 1'b1;
    en     = 1'b0;
    nextPC = 32'h40;
    tick();
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL stall_after_reset_valid actual=%b expected=0", v0); end
    checks++; if (cur0 !== 32'h0) begin errors++; $display("FAIL stall_after_reset_cur actual=%h expected=%h", cur0, 32'h0); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_seq [5];
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nextPC = exp_seq[i];
      tick();
      checks++; if (cur0 !== exp_seq[i]) begin errors++; $display("FAIL seq_%0d actual=%h expected=%h", i, cur0, exp_seq[i]); end
      checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL seq_valid_%0d actual=%b expected=1", i, v0); end
    end
    checks++; if (p40 !== 32'h14) begin errors++; $display("FAIL seq_plus4 actual=%h expected=%h", p40, 32'h14); end
  endtask

  task automatic test_branch_stall();
    en     = 1'b1;
    nextPC = 32'h8;
    tick();
    nextPC = 32'h28;
    tick();
    checks++; if (cur0 !== 32'h28) begin errors++; $display("FAIL branch actual=%h expected=%h", cur0, 32'h28); end
    en     = 1'b0;
    nextPC = 32'h99C;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cur0 !== 32'h28) begin errors++; $display("FAIL stall_%0d actual=%h expected=%h", i, cur0, 32'h28); end
    end
    en = 1'b1;
    tick();
    checks++; if (cur0 !== 32'h99C) begin errors++; $display("FAIL after_stall actual=%h expected=%h", cur0, 32'h99C); end
  endtask

  task automatic test_misaligned();
    en     = 1'b1;
    nextPC = 32'h0000_0106;
    tick();
    checks++; if (cur0 !== 32'h104) begin errors++; $display("FAIL mis_align_cur actual=%h expected=%h", cur0, 32'h104); end
    checks++; if (m0 !== 1'b1) begin errors++; $display("FAIL mis_align_flag actual=%b expected=1", m0); end
    checks++; if (cur1 !== 32'h106) begin errors++; $display("FAIL mis_raw_cur actual=%h expected=%h", cur1, 32'h106); end
    checks++; if (m1 !== 1'b1) begin errors++; $display("FAIL mis_raw_flag actual=%b expected=1", m1); end
    checks++; if (p41 !== 32'h10A) begin errors++; $display("FAIL mis_raw_plus4 actual=%h expected=%h", p41, 32'h10A); end
    // flag holds through a stall
    en     = 1'b0;
    nextPC = 32'h200;
    tick();
    checks++; if (m0 !== 1'b1) begin errors++; $display("FAIL mis_hold actual=%b expected=1", m0); end
    en     = 1'b1;
    nextPC = 32'h108;
    tick();
    checks++; if (m0 !== 1'b0) begin errors++; $display("FAIL mis_clear actual=%b expected=0", m0); end
    checks++; if (cur0 !== 32'h108) begin errors++; $display("FAIL mis_clear_cur actual=%h expected=%h", cur0, 32'h108); end
    checks++; if (m1 !== 1'b0) begin errors++; $display("FAIL mis_raw_clear actual=%b expected=0", m1); end
    nextPC = 32'h0000_0003;
    tick();
    checks++; if (cur0 !== 32'h0) begin errors++; $display("FAIL mis3_cur actual=%h expected=%h", cur0, 32'h0); end
    checks++; if (m0 !== 1'b1) begin errors++; $display("FAIL mis3_flag actual=%b expected=1", m0); end
  endtask

  task automatic test_wrap();
    en     = 1'b1;
    nextPC = 32'hFFFF_FFFC;
    tick();
    checks++; if (cur0 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_cur actual=%h expected=%h", cur0, 32'hFFFF_FFFC); end
    checks++; if (p40 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 actual=%h expected=%h", p40, 32'h0); end
    nextPC = 32'h0;
    tick();
    checks++; if (cur0 !== 32'h0) begin errors++; $display("FAIL wrap_feed_cur actual=%h expected=%h", cur0, 32'h0); end
    checks++; if (m0 !== 1'b0) begin errors++; $display("FAIL wrap_feed_mis actual=%b expected=0", m0); end
  endtask

  task automatic test_self_loop();
    en     = 1'b1;
    nextPC = 32'h300;
    tick();
    for (int i = 0; i < 2; i++) begin
      nextPC = 32'h300;
      tick();
      checks++; if (cur0 !== 32'h300) begin errors++; $display("FAIL self_loop_%0d actual=%h expected=%h", i, cur0, 32'h300); end
    end
  endtask

  task automatic test_reset_vector();
    #2;
    reset  = 1'b0;
    en     = 1'b1;
    nextPC = 32'h5550;
    #1;
    checks++; if (cur2 !== 32'h1000) begin errors++; $display("FAIL rv_cur actual=%h expected=%h", cur2, 32'h1000); end
    checks++; if (p42 !== 32'h1004) begin errors++; $display("FAIL rv_plus4 actual=%h expected=%h", p42, 32'h1004); end
    checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL rv_valid actual=%b expected=0", v2); end
    tick();
    checks++; if (cur2 !== 32'h1000) begin errors++; $display("FAIL rv_no_load actual=%h expected=%h", cur2, 32'h1000); end
    reset  = 1'b1;
    nextPC = 32'h1004;
    tick();
    checks++; if (cur2 !== 32'h1004) begin errors++; $display("FAIL rv_first_load actual=%h expected=%h", cur2, 32'h1004); end
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL rv_first_valid actual=%b expected=1", v2); end
    checks++; if (m2 !== 1'b0) begin errors++; $display("FAIL rv_mis actual=%b expected=0", m2); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    en     = 1'b0;
    nextPC = 32'h0;
    test_reset();
    test_sequential();
    test_branch_stall();
    test_misaligned();
    test_wrap();
    test_self_loop();
    test_reset_vector();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
